// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-arithmetic datapath: operand width,
// the modular multiplier FSM state encoding and the P-256 field prime.
package ecc_pkg;

  localparam int WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

endpackage

// File: rtl/mod_mul_step.sv
// One radix-2 interleaved modular multiplication iteration:
//   P <- 2P mod M, then if b: P <- (P + A) mod M.
// All arithmetic is WIDTH+2 bits wide so 2P and P+A never overflow.
module mod_mul_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH+1:0] p_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic             b_in,
  output logic [WIDTH+1:0] p_out
);

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] p_dbl;
  logic [WIDTH+1:0] p_dbl_red;
  logic [WIDTH+1:0] p_add;

  // Double, reduce, conditionally add the multiplicand, reduce again.
  always_comb begin
    m_ext     = {2'b00, m_in};
    a_ext     = {2'b00, a_in};
    p_dbl     = p_in << 1;
    p_dbl_red = (p_dbl >= m_ext) ? (p_dbl - m_ext) : p_dbl;
    p_add     = b_in ? (p_dbl_red + a_ext) : p_dbl_red;
    p_out     = (p_add >= m_ext) ? (p_add - m_ext) : p_add;
  end

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: out_data = (opA * opB) mod opM, one
// multiplier bit per clock, MSB first, 256 iterations per operation.
// Optional build macro MODMUL_RANGE_CHECK_EN flags out-of-range operands
// on err and skips straight to the result state with out_data = 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds valid and data stable until then, and
// ready never depends combinationally on valid. out_valid/out_data hold
// until out_ready is seen.
module mod_mul_serial #(
  parameter int WIDTH = ecc_pkg::WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  input  logic [WIDTH-1:0]     opM,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 err,
  output ecc_pkg::state_e      dbg_state
);
  import ecc_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH+1:0]   p_q, p_d;
  logic [WIDTH+1:0]   p_step;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;
  logic               range_bad;

`ifdef MODMUL_RANGE_CHECK_EN
  logic               err_q, err_d;
  assign range_bad = (opM < WIDTH'(2)) | (opA >= opM) | (opB >= opM);
  assign err       = err_q;
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // in_ready decodes state and is held low while reset is asserted.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

  mod_mul_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_q),
    .a_in  (a_q),
    .m_in  (m_q),
    .b_in  (b_q[cnt_q]),
    .p_out (p_step)
  );

  // State, counter, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      p_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      p_q         <= p_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next-state: accept -> RUN (or DONE on a range error), last bit -> DONE,
  // output handshake -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = range_bad ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs for each state.
  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    p_d         = p_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MODMUL_RANGE_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = opA;
          b_d   = opB;
          m_d   = opM;
          p_d   = '0;
          cnt_d = CNT_W'(WIDTH - 1);
          if (range_bad) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
`ifdef MODMUL_RANGE_CHECK_EN
            err_d       = 1'b1;
`endif
          end
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d       = '0;
          out_data_d  = p_step[WIDTH-1:0];
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef MODMUL_RANGE_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mul_serial.sv
// Self-checking bench for mod_mul_serial: directed vectors, backpressure,
// reset mid-operation, back-to-back random triples and (when built with
// MODMUL_RANGE_CHECK_EN) range-error reporting.
module tb_mod_mul_serial;
  import ecc_pkg::*;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [W-1:0] opM = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         err;
  state_e       dbg_state;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           rises   = 0;
  logic         ov_prev = 1'b0;
  logic [W-1:0] exp_q[$];

  mod_mul_serial #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .opM       (opM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // out_valid rising-edge counter, sampled away from the active edge
  always @(negedge clk) begin
    if (out_valid && !ov_prev) rises <= rises + 1;
    ov_prev <= out_valid;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: full double-width product reduced by M
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(prod % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // driver: wait for in_ready, present operands for one acceptance edge,
  // then scramble the operand bus. Returns #1 after the acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", W'(in_ready), W'(1));
    opA = a;
    opB = b;
    opM = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opA = ~a;
    opB = ~b;
    opM = ~m;
  endtask

  // wait for the result, check latency/data/err against the scoreboard;
  // if out_ready is high also check the return to IDLE.
  task automatic collect(input string tag, input int exp_lat, input logic exp_err);
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_lat > 0) check({tag, "_lat"}, W'(n), W'(exp_lat));
    check({tag, "_valid"}, W'(out_valid), W'(1));
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, W'(0), W'(1));
    else check({tag, "_data"}, out_data, exp_q.pop_front());
    check({tag, "_err"}, W'(err), W'(exp_err));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, W'(out_valid), W'(0));
      check({tag, "_ready_back"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] a, b, held;
    int           r0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", W'(in_ready), W'(1));

    // directed vectors with out_ready held high
    out_ready = 1'b1;
    exp_q.push_back(W'(15));
    send(W'(3), W'(5), P256);
    collect("t_3x5", 256, 1'b0);

    exp_q.push_back(W'(1));
    send(P256 - W'(1), P256 - W'(1), P256);
    collect("t_m1sq", 256, 1'b0);

    exp_q.push_back(W'(16'h1234));
    send(W'(16'h1234), W'(1), P256);
    collect("t_x1", 256, 1'b0);

    exp_q.push_back(W'(0));
    send(W'(0), P256 - W'(1), P256);
    collect("t_zero", 256, 1'b0);

    // backpressure: 5*6 = 30, held for 10 cycles while in_valid pulses
    out_ready = 1'b0;
    exp_q.push_back(W'(30));
    send(W'(5), W'(6), P256);
    collect("t_bp", 256, 1'b0);
    held = W'(30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_data", out_data, held);
      check("bp_in_ready", W'(in_ready), W'(0));
      in_valid = 1'b1;
      opA = W'(i + 1);
      opB = W'(2);
      opM = W'(7);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_ready", W'(in_ready), W'(1));
    check("bp_release_state", W'(dbg_state), W'(IDLE));

    // reset at iteration 100
    send(P256 - W'(1), P256 - W'(2), P256);
    repeat (100) @(posedge clk);
    #1;
    check("mid_state_run", W'(dbg_state), W'(RUN));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(out_valid), W'(0));
    check("mid_rst_ready", W'(in_ready), W'(0));
    check("mid_rst_data", out_data, W'(0));
    check("mid_rst_err", W'(err), W'(0));
    check("mid_rst_state", W'(dbg_state), W'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(W'(12));
    send(W'(7), W'(11), W'(13));
    collect("t_7x11m13", 256, 1'b0);

    // back-to-back random triples against the reference model
    r0 = rises;
    for (int i = 0; i < 50; i++) begin
      a = rand_w() % P256;
      b = rand_w() % P256;
      exp_q.push_back(model(a, b, P256));
      send(a, b, P256);
      collect("rnd", 256, 1'b0);
    end
    @(negedge clk);
    check("rnd_rises", W'(rises - r0), W'(50));

`ifdef MODMUL_RANGE_CHECK_EN
    out_ready = 1'b0;
    send(P256, W'(2), P256);
    check("rc_a_valid", W'(out_valid), W'(1));
    check("rc_a_err", W'(err), W'(1));
    check("rc_a_data", out_data, W'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rc_a_err_clr", W'(err), W'(0));
    check("rc_a_valid_clr", W'(out_valid), W'(0));
    out_ready = 1'b0;
    send(W'(0), W'(0), W'(1));
    check("rc_m1_valid", W'(out_valid), W'(1));
    check("rc_m1_err", W'(err), W'(1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rc_m1_err_clr", W'(err), W'(0));
`else
    send(P256, W'(2), P256);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 400) begin
        @(posedge clk);
        #1;
        check("norc_err_run", W'(err), W'(0));
        n++;
      end
      check("norc_valid", W'(out_valid), W'(1));
      check("norc_err", W'(err), W'(0));
    end
    @(posedge clk);
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
